// File: rtl/led_tape_pkg.sv
// Shared constants, FSM state type and slot-index helper for the WS2812B tape driver.
package led_tape_pkg;

   localparam int LED_BITS           = 24;
   localparam int TBIT_DEF           = 125;
   localparam int T0H_DEF            = 40;
   localparam int T1H_DEF            = 80;
   localparam int NUM_LEDS_DEF       = 7;
   localparam int NUM_RESET_LEDS_DEF = 4;
   localparam int NUM_W              = 16;
   localparam int BIT_IDX_W          = 5;

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_WAIT  = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   // Slot index after cur, wrapping from the last reset slot back to slot 0.
   function automatic logic [NUM_W-1:0] next_slot(input logic [NUM_W-1:0] cur,
                                                  input logic [NUM_W-1:0] last);
      return (cur == last) ? '0 : cur + 1'b1;
   endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// One WS2812B bit period: a TBIT-clock counter and a high-time comparator.
// bit_val/blank/en describe the clock that follows the coming edge, so data is a clean flop.
module ws2812_bit_tx
   import led_tape_pkg::*;
#(
   parameter int TBIT = TBIT_DEF,
   parameter int T0H  = T0H_DEF,
   parameter int T1H  = T1H_DEF
)(
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic bit_val,
   input  logic blank,
   output logic data,
   output logic bit_done
);

   localparam int            CW     = $clog2(TBIT);
   localparam logic [CW-1:0] LAST_C = CW'(TBIT - 1);
   localparam logic [CW-1:0] T0H_C  = CW'(T0H);
   localparam logic [CW-1:0] T1H_C  = CW'(T1H);

   logic [CW-1:0] cyc_q, cyc_d;
   logic          active_q, active_d;
   logic          data_q, data_d;
   logic [CW-1:0] high_time;

   always_comb begin
      active_d  = en;
      cyc_d     = '0;
      high_time = bit_val ? T1H_C : T0H_C;
      // The first enabled clock starts at index 0; afterwards the counter wraps seamlessly.
      if (en && active_q && (cyc_q != LAST_C)) begin
         cyc_d = cyc_q + 1'b1;
      end
      data_d = en && !blank && (cyc_d < high_time);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc_q    <= '0;
         active_q <= 1'b0;
         data_q   <= 1'b0;
      end else begin
         cyc_q    <= cyc_d;
         active_q <= active_d;
         data_q   <= data_d;
      end
   end

   assign data     = data_q;
   assign bit_done = active_q && (cyc_q == LAST_C);

endmodule

// File: rtl/led_tape.sv
// WS2812B chain driver: prefetches one GRB word per slot from the pixel source and
// streams LED slots followed by blank latch slots, frame after frame.
module led_tape
   import led_tape_pkg::*;
#(
   parameter int NUM_LEDS       = NUM_LEDS_DEF,
   parameter int NUM_RESET_LEDS = NUM_RESET_LEDS_DEF,
   parameter int TBIT           = TBIT_DEF,
   parameter int T0H            = T0H_DEF,
   parameter int T1H            = T1H_DEF
)(
   input  logic                clk,
   input  logic                reset_n,
   input  logic [LED_BITS-1:0] RGB,
   output logic                data,
   output logic [NUM_W-1:0]    num,
   output logic                sync,
   output logic                req
);

   localparam logic [NUM_W-1:0]     LAST_C     = NUM_W'(NUM_LEDS + NUM_RESET_LEDS - 1);
   localparam logic [NUM_W-1:0]     NUM_LEDS_C = NUM_W'(NUM_LEDS);
   localparam logic [BIT_IDX_W-1:0] MSB_IDX    = BIT_IDX_W'(LED_BITS - 1);

   state_e                state_q, state_d;
   logic                  req_q, req_d;
   logic [NUM_W-1:0]      num_q, num_d;
   logic                  sync_q, sync_d;
   logic                  cap_q, cap_d;
   logic [LED_BITS-1:0]   hold_q, hold_d;
   logic [LED_BITS-1:0]   shift_q, shift_d;
   logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
   logic                  blank_q, blank_d;
   logic [NUM_W-1:0]      next_num;
   logic                  bit_done;
   logic                  tx_en;
   logic                  tx_data;

   // cap_q marks the clock on which the source's registered RGB answer is valid.
   always_comb begin
      cap_d  = req_q;
      hold_d = cap_q ? RGB : hold_q;
   end

   always_comb begin
      state_d   = state_q;
      req_d     = 1'b0;
      num_d     = num_q;
      sync_d    = sync_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      blank_d   = blank_q;
      next_num  = next_slot(num_q, LAST_C);

      case (state_q)
         ST_START: begin
            req_d   = 1'b1;
            num_d   = '0;
            sync_d  = 1'b0;
            state_d = ST_WAIT;
         end

         ST_WAIT: begin
            // Slot 0 has no prefetched word yet, so it is taken straight from the source.
            if (cap_q) begin
               state_d   = ST_RUN;
               shift_d   = RGB;
               bit_idx_d = MSB_IDX;
               blank_d   = sync_q;
            end
         end

         ST_RUN: begin
            if (bit_done) begin
               if (bit_idx_q == '0) begin
                  shift_d   = hold_q;
                  bit_idx_d = MSB_IDX;
                  blank_d   = sync_q;
               end else begin
                  shift_d   = {shift_q[LED_BITS-2:0], 1'b0};
                  bit_idx_d = bit_idx_q - 1'b1;
                  // Bit 0 is about to start: ask for the following slot now.
                  if (bit_idx_q == BIT_IDX_W'(1)) begin
                     req_d  = 1'b1;
                     num_d  = next_num;
                     sync_d = (next_num >= NUM_LEDS_C);
                  end
               end
            end
         end

         default: begin
            state_d = ST_START;
         end
      endcase

      tx_en = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_START;
         req_q     <= 1'b0;
         num_q     <= '0;
         sync_q    <= 1'b0;
         cap_q     <= 1'b0;
         hold_q    <= '0;
         shift_q   <= '0;
         bit_idx_q <= '0;
         blank_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         num_q     <= num_d;
         sync_q    <= sync_d;
         cap_q     <= cap_d;
         hold_q    <= hold_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         blank_q   <= blank_d;
      end
   end

   ws2812_bit_tx #(
      .TBIT (TBIT),
      .T0H  (T0H),
      .T1H  (T1H)
   ) u_bit_tx (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (tx_en),
      .bit_val  (shift_d[LED_BITS-1]),
      .blank    (blank_d),
      .data     (tx_data),
      .bit_done (bit_done)
   );

   assign data = tx_data;
   assign num  = num_q;
   assign sync = sync_q;
   assign req  = req_q;

endmodule

// File: tb/tb_led_tape.sv
// Bench for led_tape: timeline model of the WS2812B waveform and prefetch handshake,
// plus hand-computed checkpoints at default timing.
module tb_led_tape;

   localparam int NLED  = 7;
   localparam int NRST  = 4;
   localparam int TOTAL = NLED + NRST;
   localparam int TBITV = 125;
   localparam int T0    = 40;
   localparam int T1    = 80;
   localparam int SLOT  = 24 * TBITV;
   localparam int REQ0  = 3 + 23 * TBITV;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [23:0] rgb;
   logic        data;
   logic [15:0] num;
   logic        sync;
   logic        req;

   int t;
   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   int src_mode = 0;

   led_tape #(
      .NUM_LEDS       (NLED),
      .NUM_RESET_LEDS (NRST),
      .TBIT           (TBITV),
      .T0H            (T0),
      .T1H            (T1)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .RGB     (rgb),
      .data    (data),
      .num     (num),
      .sync    (sync),
      .req     (req)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // Clocks elapsed since reset release; edge 1 is the first rising edge after release.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) t <= 0;
      else          t <= t + 1;
   end

   // ---------------- pixel source ----------------
   function automatic logic [23:0] src_colour(input logic [15:0] n, input logic s);
      if (src_mode == 1) return 24'hFFFFFF;
      if (s) return 24'h000000;
      return {{8{n[2]}}, {8{n[1]}}, {8{n[0]}}};
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)  rgb <= '0;
      else if (req)  rgb <= src_colour(num, sync);
   end

   // ---------------- behavioural model ----------------
   function automatic logic [23:0] model_colour(input int s);
      logic [15:0] sv;
      sv = 16'(s);
      if (src_mode == 1) return 24'hFFFFFF;
      return {{8{sv[2]}}, {8{sv[1]}}, {8{sv[0]}}};
   endfunction

   function automatic logic exp_data(input int tt);
      int u, s, b, c;
      logic [23:0] col;
      if (tt < 3) return 1'b0;
      u = tt - 3;
      s = (u / SLOT) % TOTAL;
      if (s >= NLED) return 1'b0;
      b   = 23 - (u % SLOT) / TBITV;
      c   = u % TBITV;
      col = model_colour(s);
      return (c < (col[b] ? T1 : T0));
   endfunction

   function automatic logic exp_req(input int tt);
      return (tt == 1) || (tt >= REQ0 && ((tt - REQ0) % SLOT) == 0);
   endfunction

   function automatic logic [15:0] exp_num(input int tt);
      if (tt < REQ0) return 16'd0;
      return 16'((1 + (tt - REQ0) / SLOT) % TOTAL);
   endfunction

   function automatic logic exp_sync(input int tt);
      return (exp_num(tt) >= 16'(NLED));
   endfunction

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("data", 32'(data), 32'(exp_data(t)));
         chk("req",  32'(req),  32'(exp_req(t)));
         chk("num",  32'(num),  32'(exp_num(t)));
         chk("sync", 32'(sync), 32'(exp_sync(t)));
         if (src_mode == 0) begin
            case (t)
               1: begin
                  chk("lit_req_start",  32'(req),  1);
                  chk("lit_num_start",  32'(num),  0);
                  chk("lit_sync_start", 32'(sync), 0);
               end
               2:     chk("lit_req_width",   32'(req),  0);
               3:     chk("lit_data_rise",   32'(data), 1);
               42:    chk("lit_s0_hi_last",  32'(data), 1);
               43:    chk("lit_s0_lo_first", 32'(data), 0);
               127:   chk("lit_s0_b23_end",  32'(data), 0);
               128:   chk("lit_s0_b22_rise", 32'(data), 1);
               2878: begin
                  chk("lit_req_s1", 32'(req), 1);
                  chk("lit_num_s1", 32'(num), 1);
               end
               2879:  chk("lit_req_s1_drop", 32'(req),  0);
               3003:  chk("lit_s1_rise",     32'(data), 1);
               4917:  chk("lit_s1_b8_hi",    32'(data), 1);
               4918:  chk("lit_s1_b8_lo",    32'(data), 0);
               5082:  chk("lit_s1_b7_hi",    32'(data), 1);
               5083:  chk("lit_s1_b7_lo",    32'(data), 0);
               20878: begin
                  chk("lit_req_s7",  32'(req),  1);
                  chk("lit_num_s7",  32'(num),  7);
                  chk("lit_sync_s7", 32'(sync), 1);
               end
               21003: chk("lit_blank_s7",  32'(data), 0);
               29878: begin
                  chk("lit_num_s10",  32'(num),  10);
                  chk("lit_sync_s10", 32'(sync), 1);
               end
               32878: begin
                  chk("lit_req_wrap",  32'(req),  1);
                  chk("lit_num_wrap",  32'(num),  0);
                  chk("lit_sync_wrap", 32'(sync), 0);
               end
               33003: chk("lit_frame2_rise", 32'(data), 1);
               default: ;
            endcase
         end else begin
            case (t)
               82:    chk("lit_ones_hi_last",  32'(data), 1);
               83:    chk("lit_ones_lo_first", 32'(data), 0);
               127:   chk("lit_ones_b23_end",  32'(data), 0);
               128:   chk("lit_ones_b22_rise", 32'(data), 1);
               21003: chk("lit_ones_blank",    32'(data), 0);
               default: ;
            endcase
         end
      end
   end

   // ---------------- driver ----------------
   task automatic release_reset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      chk_en = 1'b1;

      // Scenario 1: pattern source, a full frame plus part of the next.
      release_reset();
      repeat (43388) @(posedge clk);

      // Scenario 2: asynchronous reset in the middle of slot 3 while data is high.
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_data", 32'(data), 0);
      chk("async_req",  32'(req),  0);
      chk("async_num",  32'(num),  0);
      chk("async_sync", 32'(sync), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (9500) @(posedge clk);

      // Scenario 3: constant all-ones source.
      @(negedge clk);
      reset_n  = 1'b0;
      src_mode = 1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (22000) @(posedge clk);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
